// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave: APB slave exposing NUM_REGS registers of DATA_W bits.
// Writes honour per-byte PSTRB lanes. Misaligned or out-of-range addresses
// complete with pslverr. The core can stall a transfer with u_busy; a
// transfer stalled for WAIT_MAX cycles is completed with pslverr.
// A completed write with at least one strobe set raises wr_valid and
// wr_index for exactly one cycle.
module apb_regfile_slave #(
    parameter  int DATA_W   = 32,
    parameter  int ADDR_W   = 12,
    parameter  int NUM_REGS = 16,
    parameter  int WAIT_MAX = 15,
    localparam int STRB_W   = DATA_W / 8,
    localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                       pclk,
    input  logic                       preset,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [ADDR_W-1:0]          paddr,
    input  logic [DATA_W-1:0]          pwdata,
    input  logic [STRB_W-1:0]          pstrb,
    input  logic                       u_busy,
    output logic [DATA_W-1:0]          prdata,
    output logic                       pready,
    output logic                       pslverr,
    output logic                       wr_valid,
    output logic [IDX_W-1:0]           wr_index,
    output logic [NUM_REGS*DATA_W-1:0] reg_out
);

    // Byte-lane bits at the bottom of paddr; they must be zero for an access.
    localparam int                 BL         = $clog2(STRB_W);
    localparam int                 WC_W       = $clog2(WAIT_MAX + 1);
    localparam logic [ADDR_W-1:0]  LANE_MASK  = ADDR_W'((1 << BL) - 1);
    // One extra bit so a register count of 2**(ADDR_W-BL) still compares correctly.
    localparam logic [ADDR_W:0]    NUM_REGS_X = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [WC_W-1:0]    WAIT_LIMIT = WC_W'(WAIT_MAX);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    state_e                            state_q,    state_d;
    logic [ADDR_W-1:0]                 paddr_q,    paddr_d;
    logic                              pwrite_q,   pwrite_d;
    logic [DATA_W-1:0]                 pwdata_q,   pwdata_d;
    logic [STRB_W-1:0]                 pstrb_q,    pstrb_d;
    logic [WC_W-1:0]                   wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0]                 prdata_q,   prdata_d;
    logic                              pready_q,   pready_d;
    logic                              pslverr_q,  pslverr_d;
    logic                              wr_valid_q, wr_valid_d;
    logic [IDX_W-1:0]                  wr_index_q, wr_index_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]   regs_q,     regs_d;

    logic [ADDR_W-1:0]                 idx_full_s;
    logic                              dec_err_s;
    logic [DATA_W-1:0]                 rd_data_s;
    logic                              complete_s;
    logic                              err_s;
    logic                              do_write_s;
    logic [WC_W-1:0]                   wait_inc_s;

    // Decode the latched address and select the addressed register for reads.
    always_comb begin
        idx_full_s = paddr_q >> BL;
        dec_err_s  = (|(paddr_q & LANE_MASK)) || ({1'b0, idx_full_s} >= NUM_REGS_X);
        rd_data_s  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_data_s = rd_data_s | ((idx_full_s == ADDR_W'(i)) ? regs_q[i] : '0);
        end
    end

    // Next-state and next-output computation for the transfer FSM.
    always_comb begin
        state_d    = state_q;
        paddr_d    = paddr_q;
        pwrite_d   = pwrite_q;
        pwdata_d   = pwdata_q;
        pstrb_d    = pstrb_q;
        wait_cnt_d = wait_cnt_q;
        prdata_d   = prdata_q;
        wr_index_d = wr_index_q;
        regs_d     = regs_q;
        complete_s = 1'b0;
        err_s      = 1'b0;
        do_write_s = 1'b0;
        wait_inc_s = wait_cnt_q + WC_W'(1);

        case (state_q)
            S_IDLE: begin
                // Only a proper setup phase starts a transfer.
                if (psel && !penable) begin
                    paddr_d    = paddr;
                    pwrite_d   = pwrite;
                    pwdata_d   = pwdata;
                    pstrb_d    = pstrb;
                    wait_cnt_d = '0;
                    state_d    = S_ACCESS;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (!psel || !penable) begin
                    // Master abandoned the transfer: drop it silently.
                    state_d = S_IDLE;
                end else if (!u_busy) begin
                    complete_s = 1'b1;
                    err_s      = dec_err_s;
                end else if (wait_inc_s == WAIT_LIMIT) begin
                    // Core stalled too long: force an error completion.
                    wait_cnt_d = wait_inc_s;
                    complete_s = 1'b1;
                    err_s      = 1'b1;
                end else begin
                    wait_cnt_d = wait_inc_s;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (complete_s) begin
            state_d    = S_DONE;
            do_write_s = !err_s && pwrite_q;
            pready_d   = 1'b1;
            pslverr_d  = err_s;
            wr_valid_d = do_write_s && (|pstrb_q);
            wr_index_d = wr_valid_d ? idx_full_s[IDX_W-1:0] : wr_index_q;
            // Writes leave prdata untouched; errors return zero.
            prdata_d   = err_s ? '0 : (pwrite_q ? prdata_q : rd_data_s);
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < STRB_W; b++) begin
                    regs_d[i][b*8 +: 8] = (do_write_s && pstrb_q[b] && (idx_full_s == ADDR_W'(i)))
                                          ? pwdata_q[b*8 +: 8] : regs_q[i][b*8 +: 8];
                end
            end
        end else begin
            pready_d   = 1'b0;
            pslverr_d  = 1'b0;
            wr_valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q    <= S_IDLE;
            paddr_q    <= '0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
            pstrb_q    <= '0;
            wait_cnt_q <= '0;
            prdata_q   <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_index_q <= '0;
            regs_q     <= '0;
        end else begin
            state_q    <= state_d;
            paddr_q    <= paddr_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
            pstrb_q    <= pstrb_d;
            wait_cnt_q <= wait_cnt_d;
            prdata_q   <= prdata_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            wr_valid_q <= wr_valid_d;
            wr_index_q <= wr_index_d;
            regs_q     <= regs_d;
        end
    end

    assign prdata   = prdata_q;
    assign pready   = pready_q;
    assign pslverr  = pslverr_q;
    assign wr_valid = wr_valid_q;
    assign wr_index = wr_index_q;
    assign reg_out  = regs_q;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Testbench for apb_regfile_slave: directed cases plus randomized APB
// transfers against a behavioural register-array model, with a scoreboard
// queue consumed by an independent completion monitor.
module tb_apb_regfile_slave;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 12;
    localparam int NUM_REGS = 16;
    localparam int WAIT_MAX = 15;

    logic                       pclk = 1'b0;
    logic                       preset;
    logic                       psel;
    logic                       penable;
    logic                       pwrite;
    logic [ADDR_W-1:0]          paddr;
    logic [DATA_W-1:0]          pwdata;
    logic [3:0]                 pstrb;
    logic                       u_busy;
    logic [DATA_W-1:0]          prdata;
    logic                       pready;
    logic                       pslverr;
    logic                       wr_valid;
    logic [3:0]                 wr_index;
    logic [NUM_REGS*DATA_W-1:0] reg_out;

    apb_regfile_slave #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS),
        .WAIT_MAX(WAIT_MAX)
    ) dut (
        .pclk    (pclk),
        .preset  (preset),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .u_busy  (u_busy),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .wr_valid(wr_valid),
        .wr_index(wr_index),
        .reg_out (reg_out)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        wv;
        logic [3:0]  widx;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model [NUM_REGS];
    logic [31:0] model_prdata;
    int          checks = 0;
    int          passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < NUM_REGS; i++)
            chk($sformatf("reg%0d_%s", i, tag), {32'h0, reg_out[i*32 +: 32]}, {32'h0, model[i]});
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
        model_prdata = 32'h0;
    endtask

    // Completion monitor: every pready must match the oldest expectation.
    always @(negedge pclk) begin : mon
        exp_t e;
        if (pready === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pready", {63'h0, pready}, 64'h0);
            end else begin
                e = sb_q.pop_front();
                chk("pslverr", {63'h0, pslverr}, {63'h0, e.err});
                chk("prdata", {32'h0, prdata}, {32'h0, e.rdata});
                chk("wr_valid", {63'h0, wr_valid}, {63'h0, e.wv});
                if (e.wv) chk("wr_index", {60'h0, wr_index}, {60'h0, e.widx});
            end
        end else if (wr_valid !== 1'b0) begin
            chk("wr_valid_without_pready", {63'h0, wr_valid}, 64'h0);
        end
    end

    // One APB transfer with k busy cycles presented by the core.
    task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int k);
        exp_t e;
        int   idx;
        int   n;
        int   busy_left;
        int   exp_n;
        logic err;
        idx    = int'(addr) / 4;
        err    = (int'(addr) % 4 != 0) || (idx >= NUM_REGS) || (k >= WAIT_MAX);
        e.err  = err;
        e.wv   = 1'b0;
        e.widx = 4'h0;
        if (err)      e.rdata = 32'h0;
        else if (!wr) e.rdata = model[idx];
        else          e.rdata = model_prdata;
        if (!err && wr) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
            e.wv   = (strb != 4'h0);
            e.widx = idx[3:0];
        end
        model_prdata = e.rdata;
        sb_q.push_back(e);
        exp_n = (k >= WAIT_MAX) ? WAIT_MAX : k + 1;

        @(posedge pclk) #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = data; pstrb = strb; u_busy = 1'b0;
        @(posedge pclk) #1;
        penable   = 1'b1;
        busy_left = k;
        u_busy    = (busy_left > 0);
        for (n = 1; n <= 60; n++) begin
            @(posedge pclk) #1;
            if (busy_left > 0) busy_left--;
            if (pready === 1'b1) break;
            u_busy = (busy_left > 0);
        end
        chk("latency", 64'(n), 64'(exp_n));
        psel = 1'b0; penable = 1'b0; u_busy = 1'b0;
        chk_regs("after_xfer");
        @(posedge pclk) #1;
        chk("pready_one_cycle", {63'h0, pready}, 64'h0);
        chk("pslverr_cleared", {63'h0, pslverr}, 64'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] a;
        int          r;
        int          k;
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 12'h0; pwdata = 32'h0; pstrb = 4'h0; u_busy = 1'b0;
        model_reset();
        repeat (3) @(posedge pclk);
        #1 preset = 1'b0;
        chk("rst_pready", {63'h0, pready}, 64'h0);
        chk("rst_pslverr", {63'h0, pslverr}, 64'h0);
        chk("rst_prdata", {32'h0, prdata}, 64'h0);
        chk("rst_wr_valid", {63'h0, wr_valid}, 64'h0);
        chk("rst_wr_index", {60'h0, wr_index}, 64'h0);
        chk_regs("reset");

        // Full write then read back.
        xfer(1'b1, 12'h008, 32'hDEADBEEF, 4'hF, 0);
        xfer(1'b0, 12'h008, 32'h0, 4'h0, 0);
        chk("read_deadbeef", {32'h0, prdata}, 64'hDEADBEEF);

        // Byte-lane masking and empty strobe.
        xfer(1'b1, 12'h014, 32'h11223344, 4'hF, 0);
        xfer(1'b1, 12'h014, 32'hAABBCCDD, 4'b0101, 0);
        xfer(1'b0, 12'h014, 32'h0, 4'h0, 0);
        chk("strb0101_value", {32'h0, reg_out[5*32 +: 32]}, 64'h11BB33DD);
        xfer(1'b1, 12'h014, 32'h55667788, 4'b0000, 0);
        xfer(1'b0, 12'h014, 32'h0, 4'h0, 0);

        // Decode errors: out of range and misaligned.
        xfer(1'b0, 12'h040, 32'h0, 4'h0, 0);
        xfer(1'b0, 12'h002, 32'h0, 4'h0, 0);
        xfer(1'b1, 12'h042, 32'hFFFFFFFF, 4'hF, 0);

        // Busy stalls: short, just under the limit, and held past the limit.
        xfer(1'b1, 12'h00C, 32'hCAFEF00D, 4'hF, 3);
        xfer(1'b1, 12'h010, 32'h01234567, 4'hF, WAIT_MAX - 1);
        xfer(1'b1, 12'h00C, 32'h0BADBEEF, 4'hF, 100);
        xfer(1'b0, 12'h00C, 32'h0, 4'h0, WAIT_MAX);

        // Master drops psel mid-access: transfer abandoned.
        @(posedge pclk) #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h018;
        pwdata = 32'h99999999; pstrb = 4'hF; u_busy = 1'b0;
        @(posedge pclk) #1;
        penable = 1'b1; u_busy = 1'b1;
        @(posedge pclk) #1;
        psel = 1'b0; penable = 1'b0; u_busy = 1'b0;
        repeat (4) @(posedge pclk);
        #1;
        chk("abort_pready", {63'h0, pready}, 64'h0);
        chk_regs("abort");
        xfer(1'b1, 12'h018, 32'h76543210, 4'hF, 0);
        xfer(1'b0, 12'h018, 32'h0, 4'h0, 1);

        // Randomized traffic.
        for (int t = 0; t < 150; t++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) a = 12'($urandom_range(0, 4095));
            else        a = 12'($urandom_range(0, NUM_REGS - 1) * 4);
            r = int'($urandom_range(0, 15));
            if (r < 10)      k = 0;
            else if (r < 15) k = int'($urandom_range(1, 4));
            else             k = int'($urandom_range(WAIT_MAX - 1, WAIT_MAX + 5));
            xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), k);
        end

        // Reset while a busy transfer is in flight.
        xfer(1'b1, 12'h004, 32'hA5A5A5A5, 4'hF, 0);
        xfer(1'b0, 12'h004, 32'h0, 4'h0, 0);
        @(posedge pclk) #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h004;
        pwdata = 32'h12345678; pstrb = 4'hF; u_busy = 1'b0;
        @(posedge pclk) #1;
        penable = 1'b1; u_busy = 1'b1;
        repeat (3) @(posedge pclk);
        #1 preset = 1'b1;
        @(posedge pclk) #1;
        preset = 1'b0; psel = 1'b0; penable = 1'b0; u_busy = 1'b0;
        model_reset();
        chk("inflight_rst_pready", {63'h0, pready}, 64'h0);
        chk("inflight_rst_pslverr", {63'h0, pslverr}, 64'h0);
        chk("inflight_rst_prdata", {32'h0, prdata}, 64'h0);
        chk("inflight_rst_wr_valid", {63'h0, wr_valid}, 64'h0);
        chk("inflight_rst_wr_index", {60'h0, wr_index}, 64'h0);
        chk_regs("inflight_reset");
        xfer(1'b0, 12'h004, 32'h0, 4'h0, 0);
        xfer(1'b1, 12'h03C, 32'hFEEDFACE, 4'hF, 2);
        xfer(1'b0, 12'h03C, 32'h0, 4'h0, 0);

        repeat (3) @(posedge pclk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
